parallel_sng: RTL

PARALLEL_SNG -- requirements
Module: parallel_sng

---
 rtl/parallel_sng.sv | 80 ++++++++
 1 files changed

// File: rtl/parallel_sng.sv
// Parallel stochastic number generator: emits N-bit words holding exactly `value` ones,
// rotated by an LFSR-driven offset so successive words decorrelate.
module parallel_sng #(
  parameter int unsigned K = 3,
  parameter int unsigned N = 2 ** K
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K:0]   value,
  input  logic [7:0]   frames,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         last
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e       state_q;
  logic [K:0]   val_q;
  logic [K-1:0] off_q;
  logic [7:0]   lfsr_q;
  logic [8:0]   cnt_q;

  logic [K:0]   val_sat;
  logic         lfsr_fb;

  assign val_sat = (value > (K+1)'(N)) ? (K+1)'(N) : value;
  // x^8 + x^6 + x^5 + x^4 + 1
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      val_q   <= '0;
      off_q   <= '0;
      lfsr_q  <= 8'hA5;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            val_q   <= val_sat;
            cnt_q   <= (frames == 8'd0) ? 9'd256 : {1'b0, frames};
            state_q <= StRun;
          end
        end
        StRun: begin
          if (out_ready) begin
            off_q  <= off_q + lfsr_q[K-1:0];
            lfsr_q <= {lfsr_q[6:0], lfsr_fb};
            cnt_q  <= cnt_q - 9'd1;
            if (cnt_q == 9'd1) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StRun);
  assign last      = (state_q == StRun) && (cnt_q == 9'd1);

  // Bit i is set when its distance past the offset (mod N) falls below the latched count.
  logic [K-1:0] idx;
  always_comb begin
    data_out = '0;
    idx      = '0;
    if (state_q == StRun) begin
      for (int unsigned i = 0; i < N; i++) begin
        idx         = K'(i) - off_q;
        data_out[i] = ({1'b0, idx} < val_q);
      end
    end
  end

endmodule
